mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Sits between the IFU/LSU and the memory access block.
- Serialises requests, sequences each request/response transaction, routes read data back to the owner and guards against a hung memory with a timeout.
- One transaction is outstanding at a time.

---
 rtl/mem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single data-memory port between the instruction fetch unit (IFU)
// and the load/store unit (LSU). Only one transaction is outstanding at a
// time. Each transaction runs through three phases:
//   1. Arbitration in IDLE. Only the winner sees req_ready.
//   2. The request phase, where the latched payload is presented to memory.
//   3. The response phase. Read data is routed back to the owner as a
//      one-cycle resp_valid pulse. A response that never arrives is aborted
//      after TIMEOUT_CYCLES cycles, and the sticky timeout_err flag is set.
//
// Optional feature (macro MEM_ARB_RR_EN):
//   defined   - round-robin arbitration using a 1-bit last-grant register
//   undefined - fixed priority, LSU wins over IFU
//
// Ports:
//   clock, reset          system clock, synchronous active-low reset
//   if_req_valid/ready    IFU read request handshake, if_addr
//   if_resp_valid/rdata   IFU response pulse and fetched word
//   ls_req_valid/ready    LSU request handshake, ls_wen/addr/wdata/wmask
//   ls_resp_valid/rdata   LSU response pulse and load data (0 for stores)
//   mem_req_valid/ready   memory request handshake, mem_wen/addr/wdata/wmask
//   mem_resp_valid/rdata  memory response
//   busy                  arbiter is not idle
//   timeout_err           sticky: some transaction timed out
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_wen,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                timeout_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen in the last permitted response-wait cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              owner_q;          // 1 = LSU owns the transaction
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              if_resp_valid_q;
    logic              ls_resp_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;
    logic              timeout_q;

    logic grant_ls;
    logic accept;
    logic mem_fire;
    logic resp_take;
    logic abort;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;                  // 1 = LSU was granted last

    // If both requesters are valid, the one not granted last time wins.
    // A lone requester always wins.
    assign grant_ls = ls_req_valid && (!if_req_valid || !last_grant_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant_q <= 1'b0;
        end else if (accept) begin
            last_grant_q <= grant_ls;
        end
    end
`else
    // Fixed priority: the LSU always wins when it is requesting
    assign grant_ls = ls_req_valid;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A response in the final wait cycle beats the abort,
    // but both of them return the arbiter to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (if_req_valid || ls_req_valid) state_d = REQ;
            REQ:  if (mem_req_ready) state_d = RESP;
            RESP: if (mem_resp_valid || (cnt_q == CNT_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and strobe decode. Request-side outputs are gated by reset so
    // that nothing is offered while the block is being held in reset.
    always_comb begin
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        busy          = 1'b0;
        accept        = 1'b0;
        mem_fire      = 1'b0;
        resp_take     = 1'b0;
        abort         = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept       = reset && (if_req_valid || ls_req_valid);
                ls_req_ready = accept && grant_ls;
                if_req_ready = accept && !grant_ls;
            end
            REQ: begin
                mem_req_valid = reset;
                busy          = reset;
                mem_fire      = mem_req_ready;
            end
            RESP: begin
                busy      = reset;
                resp_take = mem_resp_valid;
                abort     = !mem_resp_valid && (cnt_q == CNT_LAST);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Payload latch, the response-wait counter and response routing.
    // IFU fetches latch a clean read (no write enable, mask or data).
    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_q         <= 1'b0;
            wen_q           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            cnt_q           <= '0;
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            if_rdata_q      <= '0;
            ls_rdata_q      <= '0;
            timeout_q       <= 1'b0;
        end else begin
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;

            if (accept) begin
                owner_q <= grant_ls;
                if (grant_ls) begin
                    wen_q   <= ls_wen;
                    addr_q  <= ls_addr;
                    wdata_q <= ls_wdata;
                    wmask_q <= ls_wmask;
                end else begin
                    wen_q   <= 1'b0;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end

            if (mem_fire) begin
                cnt_q <= '0;
            end else if (state_q == RESP) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // An aborted transaction still completes toward its owner,
            // but it returns zero data.
            if (resp_take || abort) begin
                if (owner_q) begin
                    ls_resp_valid_q <= 1'b1;
                    ls_rdata_q      <= (resp_take && !wen_q) ? mem_rdata : '0;
                end else begin
                    if_resp_valid_q <= 1'b1;
                    if_rdata_q      <= resp_take ? mem_rdata : '0;
                end
            end

            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign mem_wen       = wen_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign if_resp_valid = if_resp_valid_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign if_rdata      = if_rdata_q;
    assign ls_rdata      = ls_rdata_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter, built with TIMEOUT_CYCLES = 4. The reference model
// works at the transaction level. When a grant is made, it plans the
// transaction as a few cycle numbers:
//   - the request window
//   - the response-wait window
//   - the response cycle
// Every cycle it then checks the DUT outputs against that timeline. The
// arbitration rule follows MEM_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_resp_valid;
    logic [31:0] if_rdata;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic        ls_wen = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_wmask = '0;
    logic        ls_resp_valid;
    logic [31:0] ls_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        timeout_err;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_addr(if_addr),
        .if_resp_valid(if_resp_valid),
        .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid),
        .ls_req_ready(ls_req_ready),
        .ls_wen(ls_wen),
        .ls_addr(ls_addr),
        .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid),
        .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester-side state
    bit          ifPend, lsPend, refillIf, refillLs, randomReqs, spurious;
    logic [31:0] ifAddrCur, lsAddrCur, lsWdataCur;
    logic [3:0]  lsWmaskCur;
    bit          lsWenCur;

    // Planned timeline of the outstanding transaction
    bit          txnActive, planLs, planWen, planTimeout;
    int          reqStart, reqEnd, respStart, respCycle, planD;
    logic [31:0] planData, planAddr, planWdata;
    logic [3:0]  planWmask;
    int          forceR = -1;
    int          forceD = -1;
    bit          forceDataEn;
    logic [31:0] forceData;

    // Architectural expectations
    bit          lastLs;
    logic [31:0] expIfRdata, expLsRdata;
    bit          expTimeout;

    // Observations
    bit          respSeen, respSeenLs;
    logic [31:0] respSeenData;
    bit          grantLog[$];

    typedef struct {
        bit          ifV;
        bit          lsV;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          r;
        int          d;
        logic [31:0] data;
        bit          expLs;
        logic [31:0] expRdata;
        bit          expTo;
    } vec_t;

    vec_t vecs[6];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void modelReset();
        ifPend     = 1'b0;
        lsPend     = 1'b0;
        refillIf   = 1'b0;
        refillLs   = 1'b0;
        txnActive  = 1'b0;
        lastLs     = 1'b0;
        expIfRdata = '0;
        expLsRdata = '0;
        expTimeout = 1'b0;
    endfunction

    task automatic idleInputs();
        if_req_valid   = 1'b0;
        ls_req_valid   = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic checkAllZero(input string name);
        checkVal({name, "_ctl"}, {if_req_ready, ls_req_ready, mem_req_valid, busy,
                                  timeout_err, if_resp_valid, ls_resp_valid, mem_wen}, 0);
        checkVal({name, "_ifRdata"}, if_rdata, 0);
        checkVal({name, "_lsRdata"}, ls_rdata, 0);
        checkVal({name, "_memAddr"}, mem_addr, 0);
        checkVal({name, "_memWdata"}, mem_wdata, 0);
        checkVal({name, "_memWmask"}, mem_wmask, 0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b0;
        idleInputs();
        @(negedge clock);
        #1 checkAllZero("duringReset");
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        #1 checkAllZero("afterReset");
    endtask

    // One clock cycle: drive requesters and memory, advance the model, check.
    task automatic stepCycle();
        bit inReq, inResp, expIfResp, expLsResp, expIfReady, expLsReady, winLs;
        int r;
        @(negedge clock);
        cyc++;
        if (randomReqs) begin
            if (!ifPend && $urandom_range(0, 2) == 0) begin
                ifPend    = 1'b1;
                ifAddrCur = $urandom;
            end
            if (!lsPend && $urandom_range(0, 2) == 0) begin
                lsPend     = 1'b1;
                lsWenCur   = ($urandom_range(0, 1) == 1);
                lsAddrCur  = $urandom;
                lsWdataCur = $urandom;
                lsWmaskCur = 4'($urandom_range(0, 15));
            end
        end
        if (refillIf && !ifPend) begin
            ifPend    = 1'b1;
            ifAddrCur = ifAddrCur + 32'd4;
        end
        if (refillLs && !lsPend) begin
            lsPend     = 1'b1;
            lsAddrCur  = lsAddrCur + 32'd4;
            lsWenCur   = !lsWenCur;
            lsWdataCur = $urandom;
        end
        if_req_valid = ifPend;
        if_addr      = ifAddrCur;
        ls_req_valid = lsPend;
        ls_wen       = lsWenCur;
        ls_addr      = lsAddrCur;
        ls_wdata     = lsWdataCur;
        ls_wmask     = lsWmaskCur;

        inReq  = txnActive && cyc >= reqStart && cyc <= reqEnd;
        inResp = txnActive && cyc >= respStart && cyc < respCycle;
        mem_rdata = $urandom;
        if (inReq) mem_req_ready = (cyc == reqEnd);
        else       mem_req_ready = spurious && ($urandom_range(0, 1) == 1);
        if (inResp) begin
            mem_resp_valid = !planTimeout && (cyc == respStart + planD);
            if (mem_resp_valid) mem_rdata = planData;
        end else begin
            mem_resp_valid = spurious && ($urandom_range(0, 3) == 0);
        end

        expIfResp = 1'b0;
        expLsResp = 1'b0;
        if (txnActive && cyc == respCycle) begin
            if (planLs) begin
                expLsResp  = 1'b1;
                expLsRdata = (planTimeout || planWen) ? 32'd0 : planData;
            end else begin
                expIfResp  = 1'b1;
                expIfRdata = planTimeout ? 32'd0 : planData;
            end
            if (planTimeout) expTimeout = 1'b1;
            txnActive = 1'b0;
        end

        expIfReady = 1'b0;
        expLsReady = 1'b0;
        if (!txnActive && (ifPend || lsPend)) begin
            if (ifPend && lsPend) winLs = RR_MODE ? !lastLs : 1'b1;
            else                  winLs = lsPend;
            expLsReady  = winLs;
            expIfReady  = !winLs;
            lastLs      = winLs;
            txnActive   = 1'b1;
            planLs      = winLs;
            planWen     = winLs ? lsWenCur : 1'b0;
            planAddr    = winLs ? lsAddrCur : ifAddrCur;
            planWdata   = winLs ? lsWdataCur : 32'd0;
            planWmask   = winLs ? lsWmaskCur : 4'd0;
            r           = (forceR >= 0) ? forceR : $urandom_range(0, 3);
            if (forceD >= 0) planD = forceD;
            else planD = ($urandom_range(0, 5) == 0) ? TO + 2 : $urandom_range(0, TO - 1);
            planTimeout = (planD >= TO);
            planData    = forceDataEn ? forceData : $urandom;
            reqStart    = cyc + 1;
            reqEnd      = cyc + 1 + r;
            respStart   = reqEnd + 1;
            respCycle   = respStart + (planTimeout ? TO - 1 : planD) + 1;
            if (winLs) lsPend = 1'b0;
            else       ifPend = 1'b0;
        end

        #1;
        checkVal("ifReqReady", if_req_ready, expIfReady);
        checkVal("lsReqReady", ls_req_ready, expLsReady);
        checkVal("memReqValid", mem_req_valid, inReq);
        checkVal("busy", busy, inReq || inResp);
        if (inReq) begin
            checkVal("memWen", mem_wen, planWen);
            checkVal("memAddr", mem_addr, planAddr);
            checkVal("memWdata", mem_wdata, planWdata);
            checkVal("memWmask", mem_wmask, planWmask);
        end
        checkVal("ifRespValid", if_resp_valid, expIfResp);
        checkVal("lsRespValid", ls_resp_valid, expLsResp);
        checkVal("ifRdata", if_rdata, expIfRdata);
        checkVal("lsRdata", ls_rdata, expLsRdata);
        checkVal("timeoutErr", timeout_err, expTimeout);
        if (if_req_ready) grantLog.push_back(1'b0);
        if (ls_req_ready) grantLog.push_back(1'b1);
        if (if_resp_valid || ls_resp_valid) begin
            respSeen     = 1'b1;
            respSeenLs   = ls_resp_valid;
            respSeenData = ls_resp_valid ? ls_rdata : if_rdata;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((txnActive || ifPend || lsPend) && n < 300) begin
            stepCycle();
            n++;
        end
        checkVal("drainDone", txnActive || ifPend || lsPend, 0);
        stepCycle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit expG[3];

        //                 ifV lsV wen addr          wdata         wmask r  d  data          expLs expRdata      expTo
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0,        4'h0, 0, 0, 32'h0000_0413, 1'b0, 32'h0000_0413, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 3, 1, 32'h1111_1111, 1'b1, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h8000_1004, 32'h0,        4'hF, 1, 3, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h0,        4'h0, 0, 9, 32'h2222_2222, 1'b0, 32'h0,        1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h8000_2000, 32'h0,        4'h3, 2, 0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h8000_3000, 32'h0,        4'hF, 0, 7, 32'h3333_3333, 1'b1, 32'h0,        1'b1};

        doReset();

        // Directed transactions, one requester at a time
        for (int i = 0; i < 6; i++) begin
            forceR      = vecs[i].r;
            forceD      = vecs[i].d;
            forceDataEn = 1'b1;
            forceData   = vecs[i].data;
            if (vecs[i].lsV) begin
                lsPend     = 1'b1;
                lsWenCur   = vecs[i].wen;
                lsAddrCur  = vecs[i].addr;
                lsWdataCur = vecs[i].wdata;
                lsWmaskCur = vecs[i].wmask;
            end
            if (vecs[i].ifV) begin
                ifPend    = 1'b1;
                ifAddrCur = vecs[i].addr;
            end
            respSeen = 1'b0;
            n = 0;
            while (!respSeen && n < 40) begin
                stepCycle();
                n++;
            end
            checkVal($sformatf("tbl%0d_respSeen", i), respSeen, 1);
            checkVal($sformatf("tbl%0d_owner", i), respSeenLs, vecs[i].expLs);
            checkVal($sformatf("tbl%0d_rdata", i), respSeenData, vecs[i].expRdata);
            checkVal($sformatf("tbl%0d_timeout", i), timeout_err, vecs[i].expTo);
        end
        forceDataEn = 1'b0;
        stepCycle();

        // A spurious memory response while idle must be ignored
        @(negedge clock);
        idleInputs();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_0000;
        #1 checkVal("spurIdle_busy", busy, 0);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        #1;
        checkVal("spurIdle_ifResp", if_resp_valid, 0);
        checkVal("spurIdle_lsResp", ls_resp_valid, 0);
        checkVal("spurIdle_ifRdata", if_rdata, expIfRdata);
        checkVal("spurIdle_busy2", busy, 0);
        stepCycle();

        // Reset in the response phase, with the memory answering in that same
        // cycle. The reset must drop the transaction silently.
        forceR    = 0;
        forceD    = 20;
        ifPend    = 1'b1;
        ifAddrCur = 32'h8000_0040;
        n = 0;
        while (!(txnActive && cyc >= respStart) && n < 20) begin
            stepCycle();
            n++;
        end
        checkVal("midResp_reached", txnActive && cyc >= respStart, 1);
        @(negedge clock);
        reset          = 1'b0;
        if_req_valid   = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h5555_AAAA;
        @(negedge clock);
        reset          = 1'b1;
        mem_resp_valid = 1'b0;
        modelReset();
        #1 checkAllZero("midResp");
        forceR = -1;
        forceD = -1;
        repeat (3) stepCycle();

        // Three back-to-back arbitrations with both requesters always valid
        doReset();
        grantLog.delete();
        ifAddrCur  = 32'h8000_0100;
        lsAddrCur  = 32'h8000_2000;
        lsWenCur   = 1'b0;
        lsWdataCur = 32'h0;
        lsWmaskCur = 4'hF;
        ifPend     = 1'b1;
        lsPend     = 1'b1;
        refillIf   = 1'b1;
        refillLs   = 1'b1;
        n = 0;
        while (grantLog.size() < 3 && n < 100) begin
            stepCycle();
            n++;
        end
        refillIf = 1'b0;
        refillLs = 1'b0;
        checkVal("arbGrantCount", grantLog.size() >= 3, 1);
        expG[0] = 1'b1;
        expG[1] = RR_MODE ? 1'b0 : 1'b1;
        expG[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkVal($sformatf("arbGrant%0d", k), (grantLog.size() > k) ? grantLog[k] : 1'bx, expG[k]);
        end
        drain();

        // Randomized traffic, with spurious memory handshakes outside their phases
        randomReqs = 1'b1;
        spurious   = 1'b1;
        repeat (1500) stepCycle();
        randomReqs = 1'b0;
        spurious   = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
